// File: rtl/store_buf.sv
// Posted-write buffer between execute and the RIB master port: a small FIFO
// that drains stores over req/gnt and forwards pending data to hitting loads.
module store_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_wr_en_i,
  input  logic          ex_wr_rib_req_i,
  input  logic [AW-1:0] ex_wr_addr_i,
  input  logic [DW-1:0] ex_wr_data_i,
  input  logic [AW-1:0] ex_rd_addr_i,
  output logic          fwd_hit_o,
  output logic [DW-1:0] fwd_data_o,
  output logic          hold_o,
  output logic          empty_o,
  output logic          overflow_o,
  output logic          m_req_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_data_o,
  input  logic          m_gnt_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;

  logic          w_push_req;
  logic          w_full;
  logic          w_req;
  logic          w_pop;
  logic          w_push;
  logic          w_fwd_hit;
  logic [DW-1:0] w_fwd_data;
  logic [DEPTH-1:0] w_match;
  logic [PW-1:0] w_age_idx [DEPTH];
  logic          w_unused;

  assign w_push_req = ex_wr_en_i & ex_wr_rib_req_i;
  assign w_full     = (r_count == FULL_CNT);
  assign w_req      = (r_count != '0);
  assign w_pop      = w_req & m_gnt_i;
  assign w_push     = w_push_req & (~w_full | w_pop);

  // Word-granular forwarding: the byte offset of the load address is ignored.
  assign w_unused   = &{1'b0, ex_rd_addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req & w_full & ~w_pop) r_overflow <= 1'b1;
    end
  end

  // Entry payload carries no reset; outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= ex_wr_addr_i;
      r_data[r_wr_ptr] <= ex_wr_data_i;
    end
  end

  // Slot gi holds the entry of age gi counted from the head (0 = oldest).
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign w_age_idx[gi] = r_rd_ptr + PW'(gi);
      assign w_match[gi]   = ((PW+1)'(gi) < r_count) &&
                             (r_addr[w_age_idx[gi]][AW-1:2] == ex_rd_addr_i[AW-1:2]);
    end
  endgenerate

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match[k]) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_age_idx[k]];
      end
    end
  end

  assign fwd_hit_o  = w_fwd_hit;
  assign fwd_data_o = w_fwd_data;
  assign hold_o     = w_full;
  assign empty_o    = ~w_req;
  assign overflow_o = r_overflow;
  assign m_req_o    = w_req;
  assign m_we_o     = w_req;
  assign m_addr_o   = w_req ? r_addr[r_rd_ptr] : '0;
  assign m_data_o   = w_req ? r_data[r_rd_ptr] : '0;

endmodule
